// File: rtl/hsstl_mac_phy_tdata_proc.sv
// Transmit-side PIPE-to-HSST lane adapter: builds the 46-bit P_TDATA word from the MAC's
// 32-bit PIPE TX bus and sequences HSST receiver detection for the receive-side processor.
module hsstl_mac_phy_tdata_proc #(
   parameter logic [7:0]  DET_SETTLE  = 8'd16,
   parameter logic [15:0] DET_TIMEOUT = 16'd2500
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [31:0] mac_phy_txdata,
   input  logic [3:0]  mac_phy_txdatak,
   input  logic        mac_phy_txelecidle,
   input  logic        mac_phy_txcompliance,
   input  logic        mac_phy_txdetectrx,
   input  logic [1:0]  mac_phy_powerdown,
   input  logic        lx_rxdct_done,
   input  logic        lx_rxdct_out,
   output logic [45:0] P_TDATA,
   output logic        P_RXDET_EN,
   output logic        rx_det_done,
   output logic        lx_rxdct_out_d
);

   localparam logic [45:0] TDATA_RST    = {1'b0, 1'b1, 44'd0};
   localparam logic [1:0]  PD_P1        = 2'b10;
   localparam logic [15:0] SETTLE_LAST  = {8'd0, DET_SETTLE} - 16'd1;
   localparam logic [15:0] TIMEOUT_LAST = DET_TIMEOUT - 16'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WAIT,
      ST_DONE,
      ST_HOLD
   } det_state_t;

   det_state_t  state;
   det_state_t  state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic        det_en_nxt;
   logic        det_out_nxt;
   logic        det_req;
   logic        det_abort;
   logic [45:0] tdata_p0;
   logic [45:0] tdata_p1;

   // Disparity value bit is always 0: compliance only ever forces negative disparity.
   function automatic logic [10:0] lane_word(input logic [7:0] data,
                                             input logic       k,
                                             input logic       force_disp);
      return {1'b0, force_disp, k, data};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Stage p0: combinational lane-word assembly from the PIPE inputs.
   always_comb begin
      tdata_p0 = '0;
      if (mac_phy_txelecidle) begin
         tdata_p0[44] = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            tdata_p0[11*i +: 11] = lane_word(mac_phy_txdata[8*i +: 8],
                                             mac_phy_txdatak[i],
                                             (i == 0) && mac_phy_txcompliance);
         end
      end
   end

   // Stage p1: single output register toward the HSST.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         tdata_p1 <= TDATA_RST;
      end else begin
         tdata_p1 <= tdata_p0;
      end
   end

   assign P_TDATA = tdata_p1;

   // Detection is only legal from P1 with the transmitter idle.
   assign det_req   = mac_phy_txdetectrx && mac_phy_txelecidle && (mac_phy_powerdown == PD_P1);
   assign det_abort = !mac_phy_txdetectrx || !mac_phy_txelecidle;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         P_RXDET_EN     <= 1'b0;
         lx_rxdct_out_d <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         P_RXDET_EN     <= det_en_nxt;
         lx_rxdct_out_d <= det_out_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = sat_inc(cnt);
      det_en_nxt  = P_RXDET_EN;
      det_out_nxt = lx_rxdct_out_d;
      case (state)
         ST_IDLE: begin
            if (det_req) begin
               state_nxt  = ST_SETTLE;
               cnt_nxt    = '0;
               det_en_nxt = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (det_abort) begin
               state_nxt  = ST_IDLE;
               cnt_nxt    = '0;
               det_en_nxt = 1'b0;
            end else if (cnt == SETTLE_LAST) begin
               state_nxt = ST_WAIT;
               cnt_nxt   = '0;
            end
         end
         ST_WAIT: begin
            // A completion arriving on the timeout cycle still reports the real result.
            if (det_abort) begin
               state_nxt  = ST_IDLE;
               cnt_nxt    = '0;
               det_en_nxt = 1'b0;
            end else if (lx_rxdct_done) begin
               state_nxt   = ST_DONE;
               cnt_nxt     = '0;
               det_out_nxt = lx_rxdct_out;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt   = ST_DONE;
               cnt_nxt     = '0;
               det_out_nxt = 1'b0;
            end
         end
         ST_DONE: begin
            state_nxt  = ST_HOLD;
            cnt_nxt    = '0;
            det_en_nxt = 1'b0;
         end
         ST_HOLD: begin
            if (!mac_phy_txdetectrx) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            det_en_nxt = 1'b0;
         end
      endcase
   end

   assign rx_det_done = (state == ST_DONE);

endmodule
